// File: rtl/imu_pkg.sv
// Shared definitions for the IMU front end: sequencer states,
// IMU register map, config bytes, fusion gain and SPI timing.
package imu_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    WAIT_INT,
    RD_RL,
    RD_RH,
    RD_AL,
    RD_AH,
    UPDATE
  } state_t;

  localparam logic [6:0] ADDR_INT = 7'h0D;
  localparam logic [6:0] ADDR_ACC = 7'h10;
  localparam logic [6:0] ADDR_GYR = 7'h11;
  localparam logic [6:0] ADDR_RL  = 7'h22;
  localparam logic [6:0] ADDR_RH  = 7'h23;
  localparam logic [6:0] ADDR_AL  = 7'h2A;
  localparam logic [6:0] ADDR_AH  = 7'h2B;

  localparam logic [7:0] CFG_INT = 8'h02;
  localparam logic [7:0] CFG_ACC = 8'h53;
  localparam logic [7:0] CFG_GYR = 8'h50;

  localparam int FUSE_K   = 1024;
  localparam int SCLK_DIV = 16;

  function automatic logic [15:0] wr_cmd(
    input logic [6:0] a,
    input logic [7:0] d
  );
    return {1'b0, a, d};
  endfunction

  function automatic logic [15:0] rd_cmd(
    input logic [6:0] a
  );
    return {1'b1, a, 8'h00};
  endfunction

endpackage

// File: rtl/inert_intf_if.sv
// IMU-side SPI pins, data-ready line and the ptch/ptch_rt/vld bundle.
// master: inert_intf side; slave: IMU plus balance-controller side.
interface inert_intf_if;
  logic               INT;
  logic               MISO;
  logic               SS_n;
  logic               SCLK;
  logic               MOSI;
  logic signed [15:0] ptch;
  logic signed [15:0] ptch_rt;
  logic               vld;

  modport master (
    input  INT, MISO,
    output SS_n, SCLK, MOSI,
    output ptch, ptch_rt, vld
  );

  modport slave (
    output INT, MISO,
    input  SS_n, SCLK, MOSI,
    input  ptch, ptch_rt, vld
  );
endinterface

// File: rtl/spi_mnrch.sv
// SPI master, one 16-bit MSB-first frame per wrt; SCLK idles high.
// Ports: wrt/cmd start a frame, done pulses at end, rd_data = MISO bits.
module spi_mnrch
  import imu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF = SCLK_DIV / 2;
  localparam logic [3:0] PH_FALL = 4'(HALF - 1);
  localparam logic [3:0] PH_RISE = 4'(SCLK_DIV - 1);
  localparam logic [8:0] T_FALL_END = 9'(SCLK_DIV * 16 - HALF);
  localparam logic [8:0] T_RISE_END = 9'(SCLK_DIV * 16);
  localparam logic [8:0] T_SS_RISE = 9'(SCLK_DIV * 16 + HALF - 1);
  localparam logic [8:0] T_DONE = 9'(SCLK_DIV * 16 + HALF);

  logic        busy;
  logic [8:0]  t;
  logic [15:0] shft;

  // One register shifts cmd out on falls and MISO in on rises,
  // so after 16 bits it holds exactly the received word.
  assign rd_data = shft;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      t    <= '0;
      shft <= '0;
      SS_n <= 1'b1;
      SCLK <= 1'b1;
      MOSI <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (wrt) begin
          busy <= 1'b1;
          t    <= '0;
          shft <= cmd;
          SS_n <= 1'b0;
        end
      end else begin
        t <= t + 9'd1;
        if (t[3:0] == PH_FALL && t < T_FALL_END) begin
          SCLK <= 1'b0;
          MOSI <= shft[15];
          shft <= {shft[14:0], 1'b0};
        end
        if (t[3:0] == PH_RISE && t < T_RISE_END) begin
          SCLK    <= 1'b1;
          shft[0] <= MISO;
        end
        if (t == T_SS_RISE)
          SS_n <= 1'b1;
        if (t == T_DONE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inert_intf.sv
// Inertial front end: configures the IMU, reads rate/accel per INT,
// fuses into ptch. Ports: clk, rst, bus (SPI, INT, ptch/ptch_rt/vld).
module inert_intf
  import imu_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
)(
  input  logic clk,
  input  logic rst,
  inert_intf_if.master bus
);

  localparam logic [15:0] PWR_LAST =
    FAST_SIM ? 16'd511 : 16'hFFFF;

  state_t state, state_n;

  logic [15:0]        pwr_cnt;
  logic [1:0]         init_idx;
  logic               issued;
  logic               int_ff1, int_ff2;
  logic [7:0]         rl, rh, al;
  logic signed [26:0] pi, pi_n, fuse;
  logic signed [15:0] rate, accel;
  logic               spi_st, smp_done;
  logic               wrt, done;
  logic [15:0]        cmd, rd_data;
  logic               unused_hi;

  spi_mnrch u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (bus.SS_n),
    .SCLK    (bus.SCLK),
    .MOSI    (bus.MOSI),
    .MISO    (bus.MISO)
  );

  // Read data lives in the low byte; the high byte
  // only echoes the command phase.
  assign unused_hi = ^rd_data[15:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
    end else begin
      int_ff1 <= bus.INT;
      int_ff2 <= int_ff1;
    end
  end

  always_comb begin
    state_n = state;
    spi_st  = 1'b0;
    cmd     = 16'h0000;
    unique case (state)
      PWR_WAIT:
        if (pwr_cnt == PWR_LAST) state_n = INIT;
      INIT: begin
        spi_st = 1'b1;
        unique case (init_idx)
          2'd0:    cmd = wr_cmd(ADDR_INT, CFG_INT);
          2'd1:    cmd = wr_cmd(ADDR_ACC, CFG_ACC);
          default: cmd = wr_cmd(ADDR_GYR, CFG_GYR);
        endcase
        if (done && init_idx == 2'd2) state_n = WAIT_INT;
      end
      WAIT_INT:
        if (int_ff2) state_n = RD_RL;
      RD_RL: begin
        spi_st = 1'b1;
        cmd    = rd_cmd(ADDR_RL);
        if (done) state_n = RD_RH;
      end
      RD_RH: begin
        spi_st = 1'b1;
        cmd    = rd_cmd(ADDR_RH);
        if (done) state_n = RD_AL;
      end
      RD_AL: begin
        spi_st = 1'b1;
        cmd    = rd_cmd(ADDR_AL);
        if (done) state_n = RD_AH;
      end
      RD_AH: begin
        spi_st = 1'b1;
        cmd    = rd_cmd(ADDR_AH);
        if (done) state_n = UPDATE;
      end
      UPDATE:
        state_n = WAIT_INT;
      default:
        state_n = PWR_WAIT;
    endcase
  end

  // issued keeps wrt to a single cycle per frame.
  assign wrt      = spi_st && !issued;
  assign smp_done = (state == RD_AH) && done;

  assign rate  = {rh, rl};
  assign accel = {rd_data[7:0], al};
  assign fuse  = (accel > bus.ptch) ? 27'(FUSE_K)
                                    : 27'(-FUSE_K);
  assign pi_n  = pi - {{11{rate[15]}}, rate} + fuse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PWR_WAIT;
      pwr_cnt     <= '0;
      init_idx    <= '0;
      issued      <= 1'b0;
      rl          <= '0;
      rh          <= '0;
      al          <= '0;
      pi          <= '0;
      bus.ptch    <= '0;
      bus.ptch_rt <= '0;
      bus.vld     <= 1'b0;
    end else begin
      state   <= state_n;
      bus.vld <= smp_done;
      if (state == PWR_WAIT)
        pwr_cnt <= pwr_cnt + 16'd1;
      if (wrt)
        issued <= 1'b1;
      else if (done)
        issued <= 1'b0;
      if (state == INIT && done)
        init_idx <= init_idx + 2'd1;
      if (done && state == RD_RL) rl <= rd_data[7:0];
      if (done && state == RD_RH) rh <= rd_data[7:0];
      if (done && state == RD_AL) al <= rd_data[7:0];
      if (smp_done) begin
        pi          <= pi_n;
        bus.ptch    <= pi_n[26:11];
        bus.ptch_rt <= rate;
      end
    end
  end

endmodule
